i2c_slave_regif: RTL and testbench

//   I2C target (slave) end of the passcode/OTP programming link, one byte-register file behind it.

---
 rtl/i2c_slave_regif.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regif.sv
// I2C target front end for the passcode/OTP register file: oversampled SCL/SDA decode,
// open-drain ACK/read-data drive, and one-clock register write strobes.
module i2c_slave_regif #(
  parameter logic [6:0] DEV_ADDR    = 7'h0A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_REG_ADDR,
    S_REG_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic                   scl_d_reg, sda_d_reg;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       rw_reg, rw_next;
  logic       sda_oe_reg, sda_oe_next;
  logic [7:0] reg_addr_reg, reg_addr_next;
  logic [7:0] reg_wdata_reg, reg_wdata_next;
  logic       reg_wr_en_reg, reg_wr_en_next;
  logic       busy_reg, busy_next;

  assign scl_s    = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s    = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d_reg;
  assign scl_fall = ~scl_s & scl_d_reg;
  // SDA may only move while SCL is low, so any SDA edge with SCL high is a bus condition
  assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
  assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;

  // State and datapath registers; synchronizers idle high like the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_reg  <= '1;
      sda_sync_reg  <= '1;
      scl_d_reg     <= 1'b1;
      sda_d_reg     <= 1'b1;
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= 8'h00;
      rw_reg        <= 1'b0;
      sda_oe_reg    <= 1'b0;
      reg_addr_reg  <= 8'h00;
      reg_wdata_reg <= 8'h00;
      reg_wr_en_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      scl_sync_reg  <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
      sda_sync_reg  <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
      scl_d_reg     <= scl_s;
      sda_d_reg     <= sda_s;
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      rw_reg        <= rw_next;
      sda_oe_reg    <= sda_oe_next;
      reg_addr_reg  <= reg_addr_next;
      reg_wdata_reg <= reg_wdata_next;
      reg_wr_en_reg <= reg_wr_en_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (start_det) begin
      state_next = S_DEV_ADDR;
    end else if (stop_det) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_DEV_ADDR:
          if (scl_fall && bit_cnt_reg == 4'd8)
            state_next = (shift_reg[7:1] == DEV_ADDR) ? S_DEV_ACK : S_IGNORE;
        S_DEV_ACK:
          if (scl_fall) state_next = rw_reg ? S_RD_DATA : S_REG_ADDR;
        S_REG_ADDR:
          if (scl_fall && bit_cnt_reg == 4'd8) state_next = S_REG_ACK;
        S_REG_ACK:
          if (scl_fall) state_next = S_WR_DATA;
        S_WR_DATA:
          if (scl_fall && bit_cnt_reg == 4'd8) state_next = S_WR_ACK;
        S_WR_ACK:
          if (scl_fall) state_next = S_WR_DATA;
        S_RD_DATA:
          if (scl_fall && bit_cnt_reg == 4'd8) state_next = S_RD_ACK;
        S_RD_ACK:
          if (scl_rise) state_next = sda_s ? S_IGNORE : S_RD_DATA;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    rw_next        = rw_reg;
    sda_oe_next    = sda_oe_reg;
    reg_addr_next  = reg_addr_reg;
    reg_wdata_next = reg_wdata_reg;
    reg_wr_en_next = 1'b0;
    busy_next      = busy_reg;

    if (start_det) begin
      bit_cnt_next = 4'd0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b1;
    end else if (stop_det) begin
      bit_cnt_next = 4'd0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else begin
      case (state_reg)
        S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
          if (scl_rise && bit_cnt_reg < 4'd8) begin
            shift_next   = {shift_reg[6:0], sda_s};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            bit_cnt_next = 4'd0;
            sda_oe_next  = 1'b1;
            if (state_reg == S_DEV_ADDR) begin
              rw_next     = shift_reg[0];
              sda_oe_next = (shift_reg[7:1] == DEV_ADDR);
            end else if (state_reg == S_REG_ADDR) begin
              reg_addr_next = shift_reg;
            end else begin
              reg_wdata_next = shift_reg;
              reg_wr_en_next = 1'b1;
            end
          end
        end
        S_DEV_ACK: begin
          if (scl_fall) begin
            if (rw_reg) begin
              // First read bit goes out on the same fall that ends the ACK
              shift_next   = {reg_rdata[6:0], 1'b0};
              sda_oe_next  = ~reg_rdata[7];
              bit_cnt_next = 4'd1;
            end else begin
              sda_oe_next = 1'b0;
            end
          end
        end
        S_REG_ACK: begin
          if (scl_fall) sda_oe_next = 1'b0;
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_next   = 1'b0;
            reg_addr_next = reg_addr_reg + 8'd1;
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 4'd0) begin
              shift_next   = {reg_rdata[6:0], 1'b0};
              sda_oe_next  = ~reg_rdata[7];
              bit_cnt_next = 4'd1;
            end else if (bit_cnt_reg == 4'd8) begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 4'd0;
            end else begin
              shift_next   = {shift_reg[6:0], 1'b0};
              sda_oe_next  = ~shift_reg[7];
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          // Pointer advances on the master's ACK so the next fall fetches the new byte
          if (scl_rise && !sda_s) reg_addr_next = reg_addr_reg + 8'd1;
        end
        S_IGNORE: begin
          sda_oe_next = 1'b0;
        end
        default: begin
          sda_oe_next = sda_oe_reg;
        end
      endcase
    end
  end

  assign sda_oe    = sda_oe_reg;
  assign reg_addr  = reg_addr_reg;
  assign reg_wdata = reg_wdata_reg;
  assign reg_wr_en = reg_wr_en_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench for i2c_slave_regif: bit-banged I2C master, byte-array register file and a
// transaction-level model of expected writes, read bytes and register pointer.
module tb_i2c_slave_regif;
  localparam int Q = 8;  // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, reg_wr_en, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  logic [7:0] tb_mem    [256];
  logic [7:0] model_mem [256];
  logic [7:0] model_ptr;

  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] wr_q[$];
  bit          oe_seen = 1'b0;
  int          double_wr = 0;
  logic        wr_prev = 1'b0;

  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = tb_mem[reg_addr];

  always #5 clk = ~clk;

  i2c_slave_regif #(.DEV_ADDR(7'h0A), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en), .reg_rdata(reg_rdata), .busy(busy)
  );

  // Register file behind the target plus a write-strobe recorder
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (reg_wr_en) begin
      wr_q.push_back({reg_addr, reg_wdata});
      tb_mem[reg_addr] = reg_wdata;
      if (wr_prev) double_wr++;
    end
    wr_prev = reg_wr_en;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: observed no finish, expected finish before 3ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;    qwait();
    scl_m = 1'b1; qwait();
    s = sda_line; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(~ack, s);
  endtask

  // Burst write of n bytes (packed LSB-first in w) starting at register a
  task automatic do_write(input logic [7:0] a, input logic [31:0] w, input int n);
    logic ack;
    int acks;
    logic [7:0] ea;
    wr_q.delete();
    acks = 0;
    i2c_start();
    chk("busy_after_start", busy, 1);
    write_byte(8'h14, ack); acks += int'(ack);
    write_byte(a, ack);     acks += int'(ack);
    for (int i = 0; i < n; i++) begin
      write_byte(w[8*i +: 8], ack);
      acks += int'(ack);
    end
    i2c_stop();
    chk("wr_acks", acks, n + 2);
    chk("wr_count", wr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      ea = 8'(int'(a) + i);
      model_mem[ea] = w[8*i +: 8];
      if (i < wr_q.size()) chk("wr_item", wr_q[i], {ea, w[8*i +: 8]});
    end
    model_ptr = 8'(int'(a) + n);
    chk("busy_after_stop", busy, 0);
    chk("ptr_after_wr", reg_addr, model_ptr);
    $display("write a=%02h n=%0d acks=%0d strobes=%0d", a, n, acks, wr_q.size());
  endtask

  // Pointer write, repeated START, read n bytes (last NACKed), then an ignored byte
  task automatic do_read(input logic [7:0] a, input int n);
    logic ack;
    int acks;
    logic [7:0] d;
    wr_q.delete();
    acks = 0;
    i2c_start();
    write_byte(8'h14, ack); acks += int'(ack);
    write_byte(a, ack);     acks += int'(ack);
    i2c_start();
    write_byte(8'h15, ack); acks += int'(ack);
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, d);
      chk("rd_byte", d, model_mem[8'(int'(a) + i)]);
    end
    oe_seen = 1'b0;
    read_byte(1'b0, d);
    chk("ignore_no_drive", oe_seen, 0);
    chk("busy_in_ignore", busy, 1);
    i2c_stop();
    model_ptr = 8'(int'(a) + n - 1);
    chk("rd_acks", acks, 3);
    chk("rd_no_strobe", wr_q.size(), 0);
    chk("busy_after_rd", busy, 0);
    chk("ptr_after_rd", reg_addr, model_ptr);
    $display("read  a=%02h n=%0d acks=%0d", a, n, acks);
  endtask

  // Transaction to another device address: never ACKed, never written
  task automatic do_foreign(input logic [6:0] dev, input logic [7:0] a, input logic [7:0] d);
    logic ack;
    int acks;
    wr_q.delete();
    acks = 0;
    oe_seen = 1'b0;
    i2c_start();
    write_byte({dev, 1'b0}, ack); acks += int'(ack);
    write_byte(a, ack);           acks += int'(ack);
    write_byte(d, ack);           acks += int'(ack);
    chk("foreign_acks", acks, 0);
    chk("foreign_no_drive", oe_seen, 0);
    chk("foreign_busy", busy, 1);
    i2c_stop();
    chk("foreign_no_strobe", wr_q.size(), 0);
    chk("foreign_busy_stop", busy, 0);
    chk("foreign_ptr", reg_addr, model_ptr);
    $display("foreign dev=%02h acks=%0d", dev, acks);
  endtask

  initial begin
    logic s;
    logic [7:0] v;
    logic [6:0] dev;
    int op;

    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      tb_mem[i] = v;
      model_mem[i] = v;
    end
    model_ptr = 8'h00;

    // Reset values
    repeat (4) @(posedge clk);
    #1;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_reg_wr_en", reg_wr_en, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    $display("reset released");

    // Single write to passcode register
    do_write(8'h05, 32'h0000_0050, 1);
    // Wrong device address
    do_foreign(7'h0B, 8'h05, 8'h50);
    // Burst write across the FF->00 pointer wrap
    do_write(8'hFF, 32'h0000_2211, 2);
    chk("wrap_ptr", reg_addr, 8'h01);

    // Burst read after repeated START
    tb_mem[8'h04] = 8'h11; model_mem[8'h04] = 8'h11;
    tb_mem[8'h05] = 8'h48; model_mem[8'h05] = 8'h48;
    do_read(8'h04, 2);

    // STOP after 3 data bits: partial byte discarded
    wr_q.delete();
    i2c_start();
    write_byte(8'h14, s);
    write_byte(8'h20, s);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s);
    i2c_stop();
    model_ptr = 8'h20;
    chk("partial_no_strobe", wr_q.size(), 0);
    chk("partial_sda_oe", sda_oe, 0);
    chk("partial_busy", busy, 0);
    chk("partial_ptr", reg_addr, model_ptr);
    $display("partial byte then STOP, strobes=%0d", wr_q.size());

    // Reset while the device-address ACK is held
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      v = 8'h14;
      clk_bit(v[i], s);
    end
    chk("ack_held", sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("rst_releases_ack", sda_oe, 0);
    chk("rst_busy_mid", busy, 0);
    chk("rst_ptr_mid", reg_addr, 0);
    model_ptr = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    i2c_stop();
    $display("reset during ACK, sda_oe=%0b", sda_oe);
    do_write(8'h30, 32'h0000_00A5, 1);

    // Randomized transactions against the model
    for (int t = 0; t < 14; t++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        do_write(8'($urandom), $urandom, int'($urandom_range(1, 4)));
      end else if (op == 1) begin
        do_read(8'($urandom), int'($urandom_range(1, 4)));
      end else begin
        dev = 7'($urandom_range(0, 127));
        if (dev == 7'h0A) dev = 7'h3C;
        do_foreign(dev, 8'($urandom), 8'($urandom));
      end
    end

    chk("single_clk_strobe", double_wr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
